// File: rtl/vending_pkg.sv
// Shared definitions for the vending front end: coin codes, coin_acceptor
// FSM state encoding, default debounce length and a saturating tally helper.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StQualify = 3'd1;
    localparam logic [2:0] StEmit    = 3'd2;
    localparam logic [2:0] StReject  = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    localparam int unsigned DEFAULT_DEBOUNCE = 4;

    // Adds one accepted coin (in 5-unit steps) to a running total, sticking at 255.
    function automatic logic [7:0] tally_add(input logic [7:0] total, input logic [1:0] code);
        logic [8:0] sum;
        sum = {1'b0, total} + ((code == COIN_10) ? 9'd2 : 9'd1);
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchroniser for one raw coin sensor, asynchronous active-low reset.
module coin_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_d;
    logic [1:0] sync_q;

    // Shift the raw sample through two stages.
    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    // Synchroniser flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises and debounces two coin sensors and delivers
// one-cycle coin codes to the vending machine. Jams and coins offered while
// acceptance is disabled are returned via a one-cycle reject pulse.
// Optional macro COIN_ACCEPTOR_TALLY_EN adds a saturating 8-bit tally output.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_5,
    input  logic       sense_10,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
`ifdef COIN_ACCEPTOR_TALLY_EN
    ,
    output logic [7:0] tally
`endif
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             s5;
    logic             s10;
    logic [2:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             lat10_d, lat10_q;
    logic [1:0]       coin_d, coin_q;
    logic             reject_d, reject_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             lat_s;
    logic             oth_s;

    coin_sync u_sync_5 (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (sense_5),
        .q_o    (s5)
    );

    coin_sync u_sync_10 (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (sense_10),
        .q_o    (s10)
    );

    assign cnt_inc = cnt_q + CntOne;
    // lat_s is the sensor that started this insertion, oth_s the other one.
    assign lat_s   = lat10_q ? s10 : s5;
    assign oth_s   = lat10_q ? s5 : s10;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat10_d  = lat10_q;
        coin_d   = COIN_NONE;
        reject_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (s5 && s10) begin
                    state_d = StReject;
                end else if (s5 || s10) begin
                    state_d = StQualify;
                    lat10_d = s10;
                    cnt_d   = CntOne;
                end
            end
            StQualify: begin
                if (!lat_s) begin
                    // Glitch: dropped before qualifying, discard silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (oth_s) begin
                    state_d = StReject;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntMax) begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (accept_en) begin
                    coin_d = lat10_q ? COIN_10 : COIN_5;
                end else begin
                    reject_d = 1'b1;
                end
                state_d = StRelease;
                cnt_d   = '0;
            end
            StReject: begin
                reject_d = 1'b1;
                state_d  = StRelease;
                cnt_d    = '0;
            end
            StRelease: begin
                // Both sensors must read low for a full debounce window before
                // another coin can start, so a held coin is never counted twice.
                if (s5 || s10) begin
                    cnt_d = '0;
                end else if (cnt_inc == CntMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, debounce counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lat10_q  <= 1'b0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat10_q  <= lat10_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign busy   = (state_q != StIdle);

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] tally_d, tally_q;

    // Accumulate accepted coins; lands together with the coin pulse.
    always_comb begin
        tally_d = tally_q;
        if ((state_q == StEmit) && accept_en) begin
            tally_d = tally_add(tally_q, lat10_q ? COIN_10 : COIN_5);
        end
    end

    // Tally register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tally_q <= 8'd0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign tally = tally_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed and random sensor traces, expected
// outputs computed from whole-trace scans and compared by a monitor.
module tb_coin_acceptor;
    import vending_pkg::*;

    localparam int D    = 4;
    localparam int MAXN = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sense_5 = 1'b0;
    logic       sense_10 = 1'b0;
    logic       accept_en = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic       busy;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] tally;
`endif

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sense_5   (sense_5),
        .sense_10  (sense_10),
        .accept_en (accept_en),
        .coin      (coin),
        .reject    (reject),
        .busy      (busy)
`ifdef COIN_ACCEPTOR_TALLY_EN
        ,
        .tally     (tally)
`endif
    );

    typedef struct {
        int         cyc;
        logic [1:0] code;
        bit         rej;
        int         tl;
    } ev_t;

    ev_t exp_q[$];
    bit  r5 [MAXN+3];
    bit  r10[MAXN+3];
    bit  acc[MAXN+3];
    bit  exp_busy[MAXN+3];
    int  n_len;
    int  n_checks = 0;
    int  n_errors = 0;
    int  first_coin_cyc;
    int  n_coins;
    int  n_outs;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raw input at clock k reaches the FSM decision two edges later.
    function automatic bit v5(input int k);
        return (k - 2 >= 1 && k - 2 <= n_len) ? r5[k-2] : 1'b0;
    endfunction

    function automatic bit v10(input int k);
        return (k - 2 >= 1 && k - 2 <= n_len) ? r10[k-2] : 1'b0;
    endfunction

    task automatic push_ev(input int c, input logic [1:0] cd, input bit rj, input int t);
        ev_t e;
        e.cyc = c; e.code = cd; e.rej = rj; e.tl = t;
        exp_q.push_back(e);
    endtask

    task automatic clear_trace(input int n);
        n_len = n;
        for (int i = 0; i < MAXN + 3; i++) begin
            r5[i] = 0; r10[i] = 0; acc[i] = 1; exp_busy[i] = 0;
        end
    endtask

    // Scan the whole trace and list every expected output event and busy cycle.
    task automatic build_model();
        int  k, j, r, cnt, tl;
        bit  lat10, lat, oth;
        k = 1; tl = 0;
        exp_q.delete();
        while (k <= n_len) begin
            if (!v5(k) && !v10(k)) begin
                k++;
                continue;
            end
            exp_busy[k] = 1;
            r = 0;
            if (v5(k) && v10(k)) begin
                push_ev(k + 1, COIN_NONE, 1, tl);
                r = k + 1;
            end else begin
                lat10 = v10(k); cnt = 1; j = k + 1;
                while (r == 0 && j <= n_len) begin
                    lat = lat10 ? v10(j) : v5(j);
                    oth = lat10 ? v5(j) : v10(j);
                    if (!lat) break;
                    exp_busy[j] = 1;
                    if (oth) begin
                        push_ev(j + 1, COIN_NONE, 1, tl);
                        r = j + 1;
                    end else begin
                        cnt++;
                        if (cnt == D) begin
                            if (acc[j+1]) begin
                                tl = tl + (lat10 ? 2 : 1);
                                if (tl > 255) tl = 255;
                                push_ev(j + 1, lat10 ? COIN_10 : COIN_5, 0, tl);
                            end else begin
                                push_ev(j + 1, COIN_NONE, 1, tl);
                            end
                            r = j + 1;
                        end
                    end
                    j++;
                end
                if (r == 0) begin
                    k = j + 1;
                    continue;
                end
            end
            if (r > n_len) break;
            exp_busy[r] = 1;
            cnt = 0; j = r + 1;
            while (j <= n_len) begin
                if (!v5(j) && !v10(j)) cnt++;
                else cnt = 0;
                if (cnt == D) break;
                exp_busy[j] = 1;
                j++;
            end
            k = j + 1;
        end
    endtask

    task automatic drive_trace();
        for (int k = 1; k <= n_len; k++) begin
            sense_5   = r5[k];
            sense_10  = r10[k];
            accept_en = acc[k];
            @(posedge clk);
            @(negedge clk);
        end
        sense_5 = 0; sense_10 = 0; accept_en = 0;
    endtask

    task automatic monitor();
        ev_t e;
        first_coin_cyc = -1; n_coins = 0; n_outs = 0;
        for (int k = 1; k <= n_len; k++) begin
            @(posedge clk);
            #1;
            check("busy", int'(busy), int'(exp_busy[k]));
            if (coin != COIN_NONE || reject) begin
                n_outs++;
                if (coin != COIN_NONE) begin
                    n_coins++;
                    if (first_coin_cyc < 0) first_coin_cyc = k;
                end
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL spurious output: coin=%0d reject=%0d at cycle %0d, expected none",
                             coin, reject, k);
                end else begin
                    e = exp_q.pop_front();
                    check("event cycle", k, e.cyc);
                    check("coin code", int'(coin), int'(e.code));
                    check("reject", int'(reject), int'(e.rej));
`ifdef COIN_ACCEPTOR_TALLY_EN
                    check("tally", int'(tally), e.tl);
`endif
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; n_errors++;
            $display("FAIL missing output: expected coin=%0d reject=%0d at cycle %0d, not observed",
                     e.code, e.rej, e.cyc);
        end
    endtask

    task automatic do_reset();
        rst = 0; sense_5 = 0; sense_10 = 0; accept_en = 0;
        repeat (3) @(negedge clk);
        check("reset coin", int'(coin), 0);
        check("reset reject", int'(reject), 0);
        check("reset busy", int'(busy), 0);
`ifdef COIN_ACCEPTOR_TALLY_EN
        check("reset tally", int'(tally), 0);
`endif
        rst = 1;
    endtask

    task automatic run_phase();
        do_reset();
        build_model();
        fork
            drive_trace();
            monitor();
        join
    endtask

    task automatic random_trace(input int n);
        int k, len, kind;
        bit ten;
        clear_trace(n);
        for (int i = 1; i <= n + 1; i++) acc[i] = ($urandom_range(0, 3) != 0);
        k = 1;
        while (k < n - 30) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 10);
            ten  = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                if (kind >= 2 && kind <= 6) begin
                    if (ten) r10[k+i] = (i >= 3) || ($urandom_range(0, 3) != 0);
                    else     r5[k+i]  = (i >= 3) || ($urandom_range(0, 3) != 0);
                end else if (kind == 7) begin
                    r5[k+i] = 1; r10[k+i] = 1;
                end else if (kind == 8) begin
                    r5[k+i] = 1;
                    r10[k+i] = (i >= len / 2);
                end
            end
            k = k + len;
        end
    endtask

    initial begin
        // Clean five, held long.
        clear_trace(40);
        for (int i = 1; i <= 20; i++) r5[i] = 1;
        run_phase();
        check("first coin edge", first_coin_cyc, 2 + D + 1);
        check("coin pulses held five", n_coins, 1);

        // Short ten-unit glitch.
        clear_trace(20);
        r10[1] = 1; r10[2] = 1;
        run_phase();
        check("outputs after glitch", n_outs, 0);
        check("busy after glitch", int'(busy), 0);

        // Bouncing five then steady.
        clear_trace(40);
        r5[1] = 1; r5[3] = 1; r5[4] = 1; r5[6] = 1;
        for (int i = 7; i <= 16; i++) r5[i] = 1;
        run_phase();
        check("coin pulses bounce", n_coins, 1);

        // Jam, then a clean ten.
        clear_trace(45);
        for (int i = 1; i <= 5; i++) begin r5[i] = 1; r10[i] = 1; end
        for (int i = 15; i <= 24; i++) r10[i] = 1;
        run_phase();
        check("outputs jam then ten", n_outs, 2);
        check("coin pulses jam then ten", n_coins, 1);

        // Ten refused, then ten accepted.
        clear_trace(50);
        for (int i = 1; i <= 8; i++) r10[i] = 1;
        for (int i = 1; i <= 14; i++) acc[i] = 0;
        for (int i = 20; i <= 28; i++) r10[i] = 1;
        run_phase();
        check("coin pulses refused then ten", n_coins, 1);

        // Reset in the middle of qualification.
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1; sense_5 = 1;
        repeat (5) @(posedge clk);
        #1;
        check("busy mid qualify", int'(busy), 1);
        #1 rst = 0;
        #1;
        check("async reset coin", int'(coin), 0);
        check("async reset reject", int'(reject), 0);
        check("async reset busy", int'(busy), 0);
        sense_5 = 0;
        clear_trace(45);
        for (int i = 15; i <= 25; i++) r5[i] = 1;
        run_phase();
        check("coin pulses after abort", n_coins, 1);

        // Random traces.
        for (int p = 0; p < 8; p++) begin
            random_trace(200);
            run_phase();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage feeding vending_machine: converts two raw, bouncy coin-slot sensors into clean, one-cycle coin codes on the vending_machine `coin[1:0]` input.
- Synchronises and debounces the sensors.
- Rejects jams (both sensors active) and rejects coins inserted while downstream has acceptance disabled.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a sensor must be stable to qualify a coin or a release (legal 2..15).
- CNT_W, 4, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sense_5  input  1  raw 5-unit coin sensor, asynchronous, may bounce.
- sense_10  input  1  raw 10-unit coin sensor, asynchronous, may bounce.
- accept_en  input  1  downstream permits coin delivery (sampled in EMIT only).
- coin  output  2  coin code to vending_machine; 00 none, 01 five, 10 ten, 11 never driven.
- reject  output  1  one-cycle pulse: coin returned (jam or accept_en low).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low.
- Reset (rst=0): state IDLE, counter 0, synchronisers 0, coin=00, reject=0, busy=0. Takes effect immediately and mid-operation; a partially qualified coin is discarded with no output.
- Each sensor passes through a 2-flop synchroniser; s5/s10 denote the synchroniser outputs. All decisions use s5/s10 only.
- FSM states and transitions:
  - IDLE: exactly one of s5/s10 high → QUALIFY; latch type; cnt=1. Both high → REJECT. Neither → stay.
  - QUALIFY: latched sensor high and other low → cnt+1. When cnt reaches DEBOUNCE_CYCLES → EMIT. Latched sensor drops → IDLE, no output (glitch). Other sensor rises → REJECT.
  - EMIT (one cycle): accept_en=1 → coin=latched code for exactly this cycle. accept_en=0 → reject=1 instead, coin=00. Always → RELEASE.
  - REJECT (one cycle): reject=1, coin=00 → RELEASE.
  - RELEASE: cnt counts consecutive cycles with s5=s10=0; any sensor high clears cnt. cnt reaching DEBOUNCE_CYCLES → IDLE. Prevents double-counting a held or bouncing coin.
- Outputs coin and reject are registered and never asserted together. At most one coin pulse per insertion.
- Latency: raw sensor steady high; first sampling edge counts as edge 1. coin asserts after edge 2+DEBOUNCE_CYCLES+1 (7 with default) and stays high for one cycle.
- Minimum coin-to-coin spacing is DEBOUNCE_CYCLES low cycles after release. Coins arriving during RELEASE extend RELEASE and are not counted.

Optional Feature:
- Macro COIN_ACCEPTOR_TALLY_EN.
- Defined: adds output tally[7:0]. tally is the running sum of accepted coins in 5-unit steps (+1 for five, +2 for ten), updated the cycle after EMIT with accept_en=1. Saturates at 255. Cleared by reset only. Rejected coins do not count.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vending_pkg:
  - coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10;
  - FSM state encoding IDLE/QUALIFY/EMIT/REJECT/RELEASE;
  - default debounce constant.
- One sub-module, coin_sync: 2-flop synchroniser with asynchronous active-low reset, instantiated twice.

Test Plan:
- Reset then sense_5 held high 20 cycles, accept_en=1 → exactly one coin=01 pulse, on edge 7; busy high until 4 cycles after sense_5 falls.
- sense_10 high for 2 cycles only (glitch) → no coin, no reject; FSM back in IDLE; busy low within 5 cycles.
- sense_5 bouncing (1,0,1,1,0,1 pattern) then steady high → single coin=01 only after 4 stable synchronised cycles; never two pulses.
- sense_5 and sense_10 rising on the same cycle → reject pulse one cycle; coin stays 00; next clean sense_10 insertion after release → coin=10.
- accept_en=0 during a qualified sense_10 insertion → reject=1 one cycle, coin=00. With tally enabled, tally unchanged, then +2 on the next accepted 10-unit coin.
- rst asserted mid-QUALIFY → outputs 0 asynchronously; after release no pulse for the aborted coin; a new insertion qualifies normally.
